// File: rtl/backprop_pkg.sv
// Shared definitions for the backprop cost / delta / update blocks:
// FSM state encodings and the index-width helper.
package backprop_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Width of an element index; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/backprop_delta_elem.sv
// Per-element derivative of the squared-error loss: 2*(y - label),
// wrapped modulo 2^data_size with no saturation.
module backprop_delta_elem #(
   parameter int data_size = 4
) (
   input  logic [data_size-1:0] y,
   input  logic [data_size-1:0] label,
   output logic [data_size-1:0] delta
);

   // Doubling drops the difference MSB; the result is a plain wrap.
   function automatic logic [data_size-1:0] wrap_double(input logic signed [data_size-1:0] d);
      return d <<< 1;
   endfunction

   logic signed [data_size-1:0] diff;

   assign diff  = signed'(y) - signed'(label);
   assign delta = wrap_double(diff);

endmodule

// File: rtl/backprop_delta.sv
// Output-layer gradient generator: snapshots prediction and label
// vectors on start, then streams one delta per element over valid/ready.
module backprop_delta
   import backprop_pkg::*;
#(
   parameter  int data_size = 4,
   parameter  int size      = 3,
   localparam int IDX_W     = idx_w(size)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [data_size*size-1:0] y_stream,
   input  logic [data_size*size-1:0] label_stream,
   output logic                      busy,
   output logic                      delta_valid,
   input  logic                      delta_ready,
   output logic [data_size-1:0]      delta,
   output logic [IDX_W-1:0]          delta_index,
   output logic                      done
);

   localparam int               VEC_W    = data_size * size;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(size - 1);

   state_t               state;
   logic [VEC_W-1:0]     y_snap;
   logic [VEC_W-1:0]     label_snap;
   logic [VEC_W-1:0]     y_src;
   logic [VEC_W-1:0]     label_src;
   logic [data_size-1:0] y_elem;
   logic [data_size-1:0] label_elem;
   logic [data_size-1:0] next_delta;
   int                   sel;

   // Select the element to load next: element 0 straight from the live
   // inputs on start, otherwise the following element of the snapshot.
   always_comb begin
      y_src     = (state == IDLE) ? y_stream     : y_snap;
      label_src = (state == IDLE) ? label_stream : label_snap;
      sel       = 0;
      if (state != IDLE && delta_index != LAST_IDX)
         sel = int'(delta_index) + 1;
      y_elem     = y_src[(size - sel) * data_size - 1 -: data_size];
      label_elem = label_src[(size - sel) * data_size - 1 -: data_size];
   end

   backprop_delta_elem #(
      .data_size (data_size)
   ) u_elem (
      .y     (y_elem),
      .label (label_elem),
      .delta (next_delta)
   );

   // Pass control FSM with registered outputs; delta/index only move on a
   // handshake so they stay stable under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         y_snap      <= '0;
         label_snap  <= '0;
         busy        <= 1'b0;
         delta_valid <= 1'b0;
         delta       <= '0;
         delta_index <= '0;
         done        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  y_snap      <= y_stream;
                  label_snap  <= label_stream;
                  delta_index <= '0;
                  delta       <= next_delta;
                  delta_valid <= 1'b1;
                  busy        <= 1'b1;
                  state       <= RUN;
               end
            end
            RUN: begin
               if (delta_valid && delta_ready) begin
                  if (delta_index == LAST_IDX) begin
                     delta_valid <= 1'b0;
                     done        <= 1'b1;
                     state       <= DONE;
                  end else begin
                     delta_index <= delta_index + 1'b1;
                     delta       <= next_delta;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_backprop_delta.sv
// Bench for backprop_delta: size=3 instance for streaming, backpressure,
// snapshot and reset cases; size=1 instance for the single-element corner.
module tb_backprop_delta;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [11:0] y_stream;
   logic [11:0] label_stream;
   logic        busy;
   logic        delta_valid;
   logic        delta_ready;
   logic [3:0]  delta;
   logic [1:0]  delta_index;
   logic        done;

   logic        start1;
   logic [3:0]  y1;
   logic [3:0]  l1;
   logic        busy1;
   logic        valid1;
   logic        ready1;
   logic [3:0]  delta1;
   logic [0:0]  idx1;
   logic        done1;

   int checks   = 0;
   int failures = 0;
   logic [5:0] sb_q[$];

   backprop_delta #(.data_size(4), .size(3)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .y_stream     (y_stream),
      .label_stream (label_stream),
      .busy         (busy),
      .delta_valid  (delta_valid),
      .delta_ready  (delta_ready),
      .delta        (delta),
      .delta_index  (delta_index),
      .done         (done)
   );

   backprop_delta #(.data_size(4), .size(1)) u_dut1 (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start1),
      .y_stream     (y1),
      .label_stream (l1),
      .busy         (busy1),
      .delta_valid  (valid1),
      .delta_ready  (ready1),
      .delta        (delta1),
      .delta_index  (idx1),
      .done         (done1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [11:0] pk(input int a, input int b, input int c);
      return {4'(a), 4'(b), 4'(c)};
   endfunction

   function automatic logic [3:0] exp_delta(input logic [3:0] y, input logic [3:0] l);
      logic [3:0] d;
      d = y - l;
      return {d[2:0], 1'b0};
   endfunction

   // Drive one pass on the size=3 instance; scoreboard-check every handshake
   // and hold stability, and report handshake/done/busy timing.
   task automatic run_pass(input string nm, input logic [11:0] yv, input logic [11:0] lv,
                           input logic [7:0] rdy, input int glitch_c, input int ncyc,
                           output int hs, output int done_c, output int last_hs,
                           output int busy_low_c);
      logic [5:0] exp_e;
      logic [5:0] got;
      logic [6:0] held;
      logic       stalled;
      hs = 0; done_c = -1; last_hs = -1; busy_low_c = -1; stalled = 1'b0; held = '0;
      for (int i = 0; i < 3; i++)
         sb_q.push_back({2'(i), exp_delta(yv[(2-i)*4 +: 4], lv[(2-i)*4 +: 4])});
      @(negedge clk);
      y_stream     = yv;
      label_stream = lv;
      delta_ready  = 1'b1;
      start        = 1'b1;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         start = (c == glitch_c);
         if (c == glitch_c) y_stream = 12'hFFF;
         delta_ready = (c <= 8) ? rdy[c-1] : 1'b1;
         got = {delta_index, delta};
         if (stalled) begin
            checks++;
            if ({delta_valid, got} !== held) begin
               failures++;
               $display("FAIL %s hold c=%0d got=%h exp=%h", nm, c, {delta_valid, got}, held);
            end
         end
         checks++;
         if (done && delta_valid) begin
            failures++;
            $display("FAIL %s done_valid_overlap c=%0d got=1 exp=0", nm, c);
         end
         if (done && done_c < 0) done_c = c;
         if (!busy && busy_low_c < 0) busy_low_c = c;
         if (delta_valid && delta_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
               failures++;
               $display("FAIL %s extra_element c=%0d got=%h exp=none", nm, c, got);
            end else begin
               exp_e = sb_q.pop_front();
               if (got !== exp_e) begin
                  failures++;
                  $display("FAIL %s element c=%0d got=%h exp=%h", nm, c, got, exp_e);
               end
            end
            hs++;
            last_hs = c;
         end
         stalled = delta_valid && !delta_ready;
         held    = {delta_valid, got};
      end
      start = 1'b0;
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL %s missing_elements got=%0d exp=0", nm, sb_q.size());
      end
      sb_q.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; start1 = 1'b0; delta_ready = 1'b0; ready1 = 1'b0;
      y_stream = '0; label_stream = '0; y1 = '0; l1 = '0;
      #12;
      checks++;
      if ({busy, delta_valid, delta, delta_index, done} !== 9'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=0", {busy, delta_valid, delta, delta_index, done});
      end
      checks++;
      if ({busy1, valid1, delta1, idx1, done1} !== 8'd0) begin
         failures++;
         $display("FAIL reset_outputs_size1 got=%h exp=0", {busy1, valid1, delta1, idx1, done1});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int hs, dc, lh, bl;
      run_pass("basic", pk(3, 5, 7), pk(1, 5, 9), 8'hFF, 0, 8, hs, dc, lh, bl);
      checks++; if (hs !== 3)  begin failures++; $display("FAIL basic_handshakes got=%0d exp=3", hs); end
      checks++; if (lh !== 3)  begin failures++; $display("FAIL basic_last_elem_cycle got=%0d exp=3", lh); end
      checks++; if (dc !== 4)  begin failures++; $display("FAIL basic_done_cycle got=%0d exp=4", dc); end
      checks++; if (bl !== 5)  begin failures++; $display("FAIL basic_busy_fall got=%0d exp=5", bl); end
   endtask

   task automatic test_wrap();
      int hs, dc, lh, bl;
      run_pass("wrap", pk(15, 0, 8), pk(0, 1, 0), 8'hFF, 0, 8, hs, dc, lh, bl);
      checks++; if (hs !== 3) begin failures++; $display("FAIL wrap_handshakes got=%0d exp=3", hs); end
      checks++; if (dc !== 4) begin failures++; $display("FAIL wrap_done_cycle got=%0d exp=4", dc); end
   endtask

   task automatic test_backpressure();
      int hs, dc, lh, bl;
      run_pass("backpressure", pk(3, 5, 7), pk(1, 5, 9), 8'hE9, 0, 10, hs, dc, lh, bl);
      checks++; if (hs !== 3) begin failures++; $display("FAIL bp_handshakes got=%0d exp=3", hs); end
      checks++; if (lh !== 6) begin failures++; $display("FAIL bp_last_elem_cycle got=%0d exp=6", lh); end
      checks++; if (dc !== 7) begin failures++; $display("FAIL bp_done_cycle got=%0d exp=7", dc); end
   endtask

   task automatic test_snapshot();
      int hs, dc, lh, bl;
      run_pass("snapshot", pk(3, 5, 7), pk(1, 5, 9), 8'hFF, 2, 12, hs, dc, lh, bl);
      checks++; if (hs !== 3) begin failures++; $display("FAIL snap_handshakes got=%0d exp=3", hs); end
      checks++; if (dc !== 4) begin failures++; $display("FAIL snap_done_cycle got=%0d exp=4", dc); end
      checks++; if (bl !== 5) begin failures++; $display("FAIL snap_busy_fall got=%0d exp=5", bl); end
   endtask

   task automatic test_reset_mid();
      int hs, dc, lh, bl;
      @(negedge clk);
      y_stream = pk(3, 5, 7); label_stream = pk(1, 5, 9); delta_ready = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (delta_index !== 2'd2 || !delta_valid) begin
         failures++;
         $display("FAIL rstmid_pre_index got=%0d exp=2", delta_index);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, delta_valid, delta, delta_index, done} !== 9'd0) begin
         failures++;
         $display("FAIL rstmid_async_clear got=%h exp=0", {busy, delta_valid, delta, delta_index, done});
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_no_done c=%0d got=%b exp=0", c, done);
         end
      end
      rst_n = 1'b1;
      run_pass("rstmid_restart", pk(15, 0, 8), pk(0, 1, 0), 8'hFF, 0, 8, hs, dc, lh, bl);
      checks++; if (hs !== 3) begin failures++; $display("FAIL rstmid_handshakes got=%0d exp=3", hs); end
      checks++; if (dc !== 4) begin failures++; $display("FAIL rstmid_done_cycle got=%0d exp=4", dc); end
   endtask

   task automatic test_size1();
      int hs = 0;
      int dc = -1;
      int bl = -1;
      logic [5:0] exp_e;
      logic [5:0] got;
      sb_q.push_back({2'b00, exp_delta(4'd2, 4'd3)});
      @(negedge clk);
      y1 = 4'd2; l1 = 4'd3; ready1 = 1'b1; start1 = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         start1 = 1'b0;
         got = {1'b0, idx1, delta1};
         checks++;
         if (done1 && valid1) begin
            failures++;
            $display("FAIL size1_done_valid_overlap c=%0d got=1 exp=0", c);
         end
         if (done1 && dc < 0) dc = c;
         if (!busy1 && bl < 0) bl = c;
         if (valid1 && ready1) begin
            checks++;
            if (sb_q.size() == 0) begin
               failures++;
               $display("FAIL size1_extra_element c=%0d got=%h exp=none", c, got);
            end else begin
               exp_e = sb_q.pop_front();
               if (got !== exp_e) begin
                  failures++;
                  $display("FAIL size1_element c=%0d got=%h exp=%h", c, got, exp_e);
               end
            end
            hs++;
         end
      end
      sb_q.delete();
      checks++; if (hs !== 1) begin failures++; $display("FAIL size1_handshakes got=%0d exp=1", hs); end
      checks++; if (dc !== 2) begin failures++; $display("FAIL size1_done_cycle got=%0d exp=2", dc); end
      checks++; if (bl !== 3) begin failures++; $display("FAIL size1_busy_fall got=%0d exp=3", bl); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_snapshot();
      test_reset_mid();
      test_size1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
